result_serializer: RTL and testbench

//  Downstream of the collision-detect control unit. Captures each 8-word result frame
//  (out0..out7) when the control unit raises its output write strobe (weout).

---
 rtl/result_serializer.sv | 179 +++++++++++++++++
 tb/tb_result_serializer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_serializer.sv
// result_serializer: captures 8-word result frames on the rising edge of weout,
// buffers up to DEPTH frames and replays each frame as address-tagged beats on
// a valid/ready stream.
// Optional feature macro: RESULT_CHECKSUM_EN adds a 9th XOR-checksum beat per frame.
module result_serializer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     weout,
    input  logic signed [ADDR_W-1:0] addressout,
    input  logic        [DATA_W-1:0] in0,
    input  logic        [DATA_W-1:0] in1,
    input  logic        [DATA_W-1:0] in2,
    input  logic        [DATA_W-1:0] in3,
    input  logic        [DATA_W-1:0] in4,
    input  logic        [DATA_W-1:0] in5,
    input  logic        [DATA_W-1:0] in6,
    input  logic        [DATA_W-1:0] in7,
    output logic        [DATA_W-1:0] m_data,
    output logic        [ADDR_W-1:0] m_addr,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     m_last,
    output logic                     busy,
    output logic                     overflow,
    output logic        [15:0]       frame_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH) + 1;
`ifdef RESULT_CHECKSUM_EN
    localparam int NBEATS = 9;
`else
    localparam int NBEATS = 8;
`endif
    localparam logic [3:0] LAST_BEAT = 4'(NBEATS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t state, state_next;

    logic                     weout_q;
    logic                     cap, push, pop, hs;
    logic [PTR_W-1:0]         wr_ptr, rd_ptr;
    logic [OCC_W-1:0]         occ, occ_next;
    logic [3:0]               beat;
    logic [DATA_W-1:0]        payload;

    logic signed [ADDR_W-1:0] base_mem [DEPTH];
    logic        [DATA_W-1:0] word_mem [DEPTH][8];
`ifdef RESULT_CHECKSUM_EN
    logic        [DATA_W-1:0] chk_mem  [DEPTH];
`endif

    // Beat address: frame base plus beat index, wrapping modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] beat_addr(input logic signed [ADDR_W-1:0] base,
                                                    input logic [3:0] idx);
        return base + ADDR_W'(idx);
    endfunction

`ifdef RESULT_CHECKSUM_EN
    // XOR of all eight result words of a frame.
    function automatic logic [DATA_W-1:0] frame_xor(
        input logic [DATA_W-1:0] w0, input logic [DATA_W-1:0] w1,
        input logic [DATA_W-1:0] w2, input logic [DATA_W-1:0] w3,
        input logic [DATA_W-1:0] w4, input logic [DATA_W-1:0] w5,
        input logic [DATA_W-1:0] w6, input logic [DATA_W-1:0] w7);
        return w0 ^ w1 ^ w2 ^ w3 ^ w4 ^ w5 ^ w6 ^ w7;
    endfunction
`endif

    // Edge detect on the level strobe; a frame slot is taken unless the buffer is
    // full and the head frame is not leaving in this same cycle.
    always_comb begin
        cap  = weout & ~weout_q;
        hs   = m_valid & m_ready;
        pop  = hs & m_last;
        push = cap & ((occ != OCC_W'(DEPTH)) | pop);
    end

    // Occupancy after this cycle's push/pop.
    always_comb begin
        occ_next = occ;
        if (push && !pop) begin
            occ_next = occ + OCC_W'(1);
        end else if (!push && pop) begin
            occ_next = occ - OCC_W'(1);
        end
    end

    // Frame storage: written on accepted capture, never reset.
    always_ff @(posedge clk) begin
        if (push) begin
            base_mem[wr_ptr]    <= addressout;
            word_mem[wr_ptr][0] <= in0;
            word_mem[wr_ptr][1] <= in1;
            word_mem[wr_ptr][2] <= in2;
            word_mem[wr_ptr][3] <= in3;
            word_mem[wr_ptr][4] <= in4;
            word_mem[wr_ptr][5] <= in5;
            word_mem[wr_ptr][6] <= in6;
            word_mem[wr_ptr][7] <= in7;
`ifdef RESULT_CHECKSUM_EN
            chk_mem[wr_ptr]     <= frame_xor(in0, in1, in2, in3, in4, in5, in6, in7);
`endif
        end
    end

    // Control state: strobe history, pointers, occupancy, beat index, status.
    always_ff @(posedge clk) begin
        if (rst) begin
            weout_q     <= 1'b1;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
            beat        <= '0;
            overflow    <= 1'b0;
            frame_count <= '0;
        end else begin
            weout_q <= weout;
            occ     <= occ_next;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + PTR_W'(1);
                frame_count <= frame_count + 16'd1;
            end
            if (hs) begin
                beat <= m_last ? 4'd0 : beat + 4'd1;
            end
            if (cap && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    // Stream FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Stream FSM next state: stay in SEND back-to-back while frames remain.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (occ_next != '0) state_next = SEND;
            SEND:    if (pop && (occ_next == '0)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Beat payload select for the head frame.
    always_comb begin
        payload = word_mem[rd_ptr][beat[2:0]];
`ifdef RESULT_CHECKSUM_EN
        if (beat == 4'd8) begin
            payload = chk_mem[rd_ptr];
        end
`endif
    end

    // Stream outputs, forced to zero when no beat is offered.
    always_comb begin
        m_valid = (state == SEND);
        m_last  = m_valid & (beat == LAST_BEAT);
        m_data  = m_valid ? payload : '0;
        m_addr  = m_valid ? beat_addr(base_mem[rd_ptr], beat) : '0;
        busy    = (occ != '0) | m_valid;
    end

endmodule

// File: tb/tb_result_serializer.sv
// Directed self-checking bench for result_serializer.
module tb_result_serializer;

`ifdef RESULT_CHECKSUM_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               weout;
    logic signed [31:0] addressout;
    logic [31:0]        in0, in1, in2, in3, in4, in5, in6, in7;
    logic [31:0]        m_data;
    logic [31:0]        m_addr;
    logic               m_valid;
    logic               m_ready;
    logic               m_last;
    logic               busy;
    logic               overflow;
    logic [15:0]        frame_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] fw [4][8];
    logic [31:0] fb [4];

    result_serializer #(.DATA_W(32), .ADDR_W(32), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .weout(weout), .addressout(addressout),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .in4(in4), .in5(in5), .in6(in6), .in7(in7),
        .m_data(m_data), .m_addr(m_addr), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .busy(busy), .overflow(overflow), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_data(input int f, input int i);
        logic [31:0] x;
        if (i < 8) return fw[f][i];
        x = 32'h0;
        for (int k = 0; k < 8; k++) x = x ^ fw[f][k];
        return x;
    endfunction

    function automatic logic [31:0] exp_addr(input int f, input int i);
        return fb[f] + 32'(i);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; weout = 1'b0; m_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic drive_frame(input int f);
        addressout = fb[f];
        in0 = fw[f][0]; in1 = fw[f][1]; in2 = fw[f][2]; in3 = fw[f][3];
        in4 = fw[f][4]; in5 = fw[f][5]; in6 = fw[f][6]; in7 = fw[f][7];
    endtask

    task automatic test_reset();
        rst = 1'b1; weout = 1'b1; m_ready = 1'b0; drive_frame(0);
        repeat (3) tick();
        n_tests += 7;
        if (m_data !== 32'h0)       begin n_fail++; $display("FAIL reset_m_data got %h want 0", m_data); end
        if (m_addr !== 32'h0)       begin n_fail++; $display("FAIL reset_m_addr got %h want 0", m_addr); end
        if (m_valid !== 1'b0)       begin n_fail++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
        if (m_last !== 1'b0)        begin n_fail++; $display("FAIL reset_m_last got %b want 0", m_last); end
        if (busy !== 1'b0)          begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        if (overflow !== 1'b0)      begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
        if (frame_count !== 16'h0)  begin n_fail++; $display("FAIL reset_frame_count got %h want 0", frame_count); end
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_tests += 2;
            if (m_valid !== 1'b0) begin n_fail++; $display("FAIL stale_capture_valid cycle %0d got %b want 0", c, m_valid); end
            if (busy !== 1'b0)    begin n_fail++; $display("FAIL stale_capture_busy cycle %0d got %b want 0", c, busy); end
        end
        weout = 1'b0;
        tick();
    endtask

    task automatic test_single_frame();
        int idx = 0;
        int first = -1;
        int lastc = -1;
        do_reset();
        m_ready = 1'b1; drive_frame(0); weout = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (c == 3) weout = 1'b0;
            if (m_valid && idx < NB) begin
                n_tests += 3;
                if (m_data !== exp_data(0, idx)) begin n_fail++; $display("FAIL single_data beat %0d got %h want %h", idx, m_data, exp_data(0, idx)); end
                if (m_addr !== exp_addr(0, idx)) begin n_fail++; $display("FAIL single_addr beat %0d got %h want %h", idx, m_addr, exp_addr(0, idx)); end
                if (m_last !== (idx == NB - 1))  begin n_fail++; $display("FAIL single_last beat %0d got %b want %b", idx, m_last, (idx == NB - 1)); end
                if (first < 0) first = c;
                lastc = c;
                idx++;
            end else if (m_valid) begin
                n_tests++; n_fail++; $display("FAIL single_extra_beat got beat %0d want none", idx);
                idx++;
            end
        end
        n_tests += 5;
        if (first !== 0)           begin n_fail++; $display("FAIL single_latency got cycle %0d want 0", first); end
        if (idx !== NB)            begin n_fail++; $display("FAIL single_beats got %0d want %0d", idx, NB); end
        if (lastc !== NB - 1)      begin n_fail++; $display("FAIL single_contiguous got last cycle %0d want %0d", lastc, NB - 1); end
        if (frame_count !== 16'd1) begin n_fail++; $display("FAIL single_frame_count got %0d want 1", frame_count); end
        if (busy !== 1'b0)         begin n_fail++; $display("FAIL single_busy_end got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        int idx = 0;
        do_reset();
        drive_frame(1); weout = 1'b1;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (c == 3) weout = 1'b0;
            m_ready = ((c % 4) == 0) || ((c % 4) == 3);
            if (m_valid) begin
                if (idx >= NB) begin
                    n_tests++; n_fail++; $display("FAIL bp_extra_beat got beat %0d want none", idx);
                end else begin
                    n_tests += 3;
                    if (m_data !== exp_data(1, idx)) begin n_fail++; $display("FAIL bp_data beat %0d got %h want %h", idx, m_data, exp_data(1, idx)); end
                    if (m_addr !== exp_addr(1, idx)) begin n_fail++; $display("FAIL bp_addr beat %0d got %h want %h", idx, m_addr, exp_addr(1, idx)); end
                    if (m_last !== (idx == NB - 1))  begin n_fail++; $display("FAIL bp_last beat %0d got %b want %b", idx, m_last, (idx == NB - 1)); end
                end
                if (m_ready) idx++;
            end
        end
        m_ready = 1'b0;
        n_tests += 2;
        if (idx !== NB)            begin n_fail++; $display("FAIL bp_beats got %0d want %0d", idx, NB); end
        if (frame_count !== 16'd1) begin n_fail++; $display("FAIL bp_frame_count got %0d want 1", frame_count); end
    endtask

    task automatic test_overflow();
        int idx = 0;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            if ((c % 2) == 0) begin drive_frame(c / 2); weout = 1'b1; end
            else weout = 1'b0;
            tick();
        end
        n_tests += 4;
        if (overflow !== 1'b1)     begin n_fail++; $display("FAIL ovf_flag got %b want 1", overflow); end
        if (busy !== 1'b1)         begin n_fail++; $display("FAIL ovf_busy got %b want 1", busy); end
        if (m_valid !== 1'b1)      begin n_fail++; $display("FAIL ovf_valid_stalled got %b want 1", m_valid); end
        if (frame_count !== 16'd0) begin n_fail++; $display("FAIL ovf_count_stalled got %0d want 0", frame_count); end
        m_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (m_valid) begin
                if (idx >= 2 * NB) begin
                    n_tests++; n_fail++; $display("FAIL ovf_dropped_frame_sent got beat %0d want none", idx);
                end else begin
                    n_tests += 2;
                    if (m_data !== exp_data(idx / NB, idx % NB)) begin n_fail++; $display("FAIL ovf_data beat %0d got %h want %h", idx, m_data, exp_data(idx / NB, idx % NB)); end
                    if (m_addr !== exp_addr(idx / NB, idx % NB)) begin n_fail++; $display("FAIL ovf_addr beat %0d got %h want %h", idx, m_addr, exp_addr(idx / NB, idx % NB)); end
                end
                idx++;
            end
            tick();
        end
        m_ready = 1'b0;
        n_tests += 4;
        if (idx !== 2 * NB)        begin n_fail++; $display("FAIL ovf_beats got %0d want %0d", idx, 2 * NB); end
        if (frame_count !== 16'd2) begin n_fail++; $display("FAIL ovf_frame_count got %0d want 2", frame_count); end
        if (overflow !== 1'b1)     begin n_fail++; $display("FAIL ovf_sticky got %b want 1", overflow); end
        if (m_valid !== 1'b0)      begin n_fail++; $display("FAIL ovf_idle_end got %b want 0", m_valid); end
    endtask

    task automatic test_full_pop();
        int idx = 0;
        int hold = 0;
        int order [3] = '{0, 1, 2};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            if ((c % 2) == 0) begin drive_frame(c / 2); weout = 1'b1; end
            else weout = 1'b0;
            tick();
        end
        m_ready = 1'b1;
        for (int c = 0; c < 40 && idx < 3 * NB; c++) begin
            if (hold > 0) begin
                hold--;
                if (hold == 0) weout = 1'b0;
            end
            n_tests++;
            if (!m_valid) begin
                n_fail++; $display("FAIL fullpop_bubble at beat %0d got valid 0 want 1", idx);
            end else begin
                if (m_data !== exp_data(order[idx / NB], idx % NB)) begin n_fail++; $display("FAIL fullpop_data beat %0d got %h want %h", idx, m_data, exp_data(order[idx / NB], idx % NB)); end
                if (idx == NB - 1) begin
                    drive_frame(2); weout = 1'b1; hold = 2;
                end
                idx++;
            end
            tick();
        end
        weout = 1'b0; m_ready = 1'b0;
        n_tests += 4;
        if (idx !== 3 * NB)        begin n_fail++; $display("FAIL fullpop_beats got %0d want %0d", idx, 3 * NB); end
        if (overflow !== 1'b0)     begin n_fail++; $display("FAIL fullpop_overflow got %b want 0", overflow); end
        if (frame_count !== 16'd3) begin n_fail++; $display("FAIL fullpop_frame_count got %0d want 3", frame_count); end
        if (busy !== 1'b0)         begin n_fail++; $display("FAIL fullpop_busy_end got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_frame();
        int idx = 0;
        do_reset();
        m_ready = 1'b1; drive_frame(0); weout = 1'b1;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            tick();
            if (m_valid) idx++;
        end
        weout = 1'b0;
        n_tests++;
        if (m_data !== exp_data(0, 3)) begin n_fail++; $display("FAIL midrst_pre_data got %h want %h", m_data, exp_data(0, 3)); end
        tick();
        rst = 1'b1;
        tick();
        n_tests += 4;
        if (m_valid !== 1'b0)      begin n_fail++; $display("FAIL midrst_valid got %b want 0", m_valid); end
        if (busy !== 1'b0)         begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
        if (m_data !== 32'h0)      begin n_fail++; $display("FAIL midrst_data got %h want 0", m_data); end
        if (frame_count !== 16'd0) begin n_fail++; $display("FAIL midrst_count got %0d want 0", frame_count); end
        rst = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (m_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_no_tail got %b want 0", m_valid); end
    endtask

`ifdef RESULT_CHECKSUM_EN
    task automatic test_checksum();
        int idx = 0;
        do_reset();
        m_ready = 1'b1; drive_frame(3); weout = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            weout = 1'b0;
            if (m_valid) begin
                if (idx == 7) begin
                    n_tests++;
                    if (m_last !== 1'b0) begin n_fail++; $display("FAIL chk_beat7_last got %b want 0", m_last); end
                end
                if (idx == 8) begin
                    n_tests += 3;
                    if (m_data !== 32'h0000_00FF) begin n_fail++; $display("FAIL chk_data got %h want 000000ff", m_data); end
                    if (m_addr !== 32'h0000_0048) begin n_fail++; $display("FAIL chk_addr got %h want 00000048", m_addr); end
                    if (m_last !== 1'b1)          begin n_fail++; $display("FAIL chk_last got %b want 1", m_last); end
                end
                idx++;
            end
        end
        n_tests++;
        if (idx !== 9) begin n_fail++; $display("FAIL chk_beats got %0d want 9", idx); end
    endtask
`endif

    initial begin
        rst = 1'b1; weout = 1'b0; m_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            fw[0][k] = 32'h100 + 32'(k);
            fw[1][k] = 32'hA000_0000 + 32'(k * 32'h11);
            fw[2][k] = 32'h5555_0000 ^ 32'(k << 4);
            fw[3][k] = 32'h1 << k;
        end
        fb[0] = 32'd7;
        fb[1] = 32'hFFFF_FFFC;
        fb[2] = 32'h0000_1000;
        fb[3] = 32'h0000_0040;
        drive_frame(0);

        test_reset();
        test_single_frame();
        test_backpressure();
        test_overflow();
        test_full_pop();
        test_reset_mid_frame();
`ifdef RESULT_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
